// File: rtl/tone_arbiter.sv
// -----------------------------------------------------------------------------
// tone_arbiter
//
// Shares one tone generator between the live keyboard path and the autoplay
// song player. Live play always wins. Every note change or ownership change
// inserts GAP_CYCLES silent cycles so consecutive strikes are heard separately.
// After a live key is released, a LIVE_HOLD hold-off keeps autoplay from
// grabbing the output straight away.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   live_on      live note valid (key controller)
//   live_note    live note code
//   auto_req     autoplay requests the output, held for the whole note
//   auto_note    autoplay note code
//   tone_on      tone generator enable
//   tone_note    note code to the tone generator
//   owner        00 none, 01 live, 10 autoplay (11 never driven)
//   auto_grant   autoplay currently owns a sounding output
//   auto_preempt one-cycle pulse when autoplay loses ownership to live
//
// All outputs come from registers only (state, note latch, preempt flag);
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module tone_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int LIVE_HOLD  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       live_on,
    input  logic [3:0] live_note,
    input  logic       auto_req,
    input  logic [3:0] auto_note,
    output logic       tone_on,
    output logic [3:0] tone_note,
    output logic [1:0] owner,
    output logic       auto_grant,
    output logic       auto_preempt
);

    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);
    localparam logic [7:0] HOLD_LOAD = 8'(LIVE_HOLD);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LIVE = 3'd1,
        S_AUTO = 3'd2,
        S_GAP  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    typedef enum logic {
        T_LIVE = 1'b0,
        T_AUTO = 1'b1
    } target_t;

    state_t     state_q,   state_d;
    target_t    target_q,  target_d;
    logic [3:0] latch_q,   latch_d;
    logic [7:0] count_q,   count_d;
    logic       preempt_q, preempt_d;

    // The counter is loaded with the full window length on entry, so the
    // value 1 marks the last silent cycle of GAP or HOLD.
    logic count_last;
    assign count_last = (count_q <= 8'd1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            target_q  <= T_LIVE;
            latch_q   <= 4'd0;
            count_q   <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            latch_q   <= latch_d;
            count_q   <= count_d;
            preempt_q <= preempt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        latch_d   = latch_q;
        count_d   = count_q;
        preempt_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Live has priority when both request on the same cycle.
                if (live_on) begin
                    state_d = S_LIVE;
                    latch_d = live_note;
                end else if (auto_req) begin
                    state_d = S_AUTO;
                    latch_d = auto_note;
                end
            end

            S_LIVE: begin
                if (!live_on) begin
                    state_d = S_HOLD;
                    count_d = HOLD_LOAD;
                end else if (live_note != latch_q) begin
                    state_d  = S_GAP;
                    target_d = T_LIVE;
                    count_d  = GAP_LOAD;
                end
            end

            S_AUTO: begin
                if (live_on) begin
                    state_d   = S_GAP;
                    target_d  = T_LIVE;
                    count_d   = GAP_LOAD;
                    preempt_d = 1'b1;
                end else if (!auto_req) begin
                    state_d = S_IDLE;
                end else if (auto_note != latch_q) begin
                    state_d  = S_GAP;
                    target_d = T_AUTO;
                    count_d  = GAP_LOAD;
                end
            end

            S_GAP: begin
                count_d = count_q - 8'd1;
                // A live press during an autoplay gap steals the gap without
                // restarting it; the exit decision below uses the new target.
                if (target_q == T_AUTO && live_on) begin
                    target_d  = T_LIVE;
                    preempt_d = 1'b1;
                end
                if (count_last) begin
                    if (target_d == T_LIVE) begin
                        if (live_on) begin
                            state_d = S_LIVE;
                            latch_d = live_note;
                        end else begin
                            state_d = S_HOLD;
                            count_d = HOLD_LOAD;
                        end
                    end else begin
                        if (auto_req) begin
                            state_d = S_AUTO;
                            latch_d = auto_note;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            S_HOLD: begin
                count_d = count_q - 8'd1;
                // Output is already silent, so a new press needs no gap.
                if (live_on) begin
                    state_d = S_LIVE;
                    latch_d = live_note;
                end else if (count_last) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: state and latch only)
    // ------------------------------------------------------------------
    always_comb begin
        tone_on    = 1'b0;
        owner      = 2'b00;
        auto_grant = 1'b0;
        unique case (state_q)
            S_LIVE: begin
                tone_on = 1'b1;
                owner   = 2'b01;
            end
            S_AUTO: begin
                tone_on    = 1'b1;
                owner      = 2'b10;
                auto_grant = 1'b1;
            end
            default: begin
                tone_on    = 1'b0;
                owner      = 2'b00;
                auto_grant = 1'b0;
            end
        endcase
    end

    // The latch only changes on entry to LIVE or AUTO, so silent states
    // keep presenting the last sounded note.
    assign tone_note    = latch_q;
    assign auto_preempt = preempt_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tone_arbiter
//
// Self-checking bench for tone_arbiter. A stimulus process applies inputs just
// after each rising edge and advances a behavioural model of the arbitration
// rules, pushing the outputs expected for that cycle into exp_q. A monitor on
// the falling edge pops one entry per cycle and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_tone_arbiter;

    localparam int GAP  = 4;
    localparam int HOLD = 8;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst;
    logic       live_on;
    logic [3:0] live_note;
    logic       auto_req;
    logic [3:0] auto_note;
    logic       tone_on;
    logic [3:0] tone_note;
    logic [1:0] owner;
    logic       auto_grant;
    logic       auto_preempt;

    always #5 clk = ~clk;

    tone_arbiter #(
        .GAP_CYCLES(GAP),
        .LIVE_HOLD (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .live_on     (live_on),
        .live_note   (live_note),
        .auto_req    (auto_req),
        .auto_note   (auto_note),
        .tone_on     (tone_on),
        .tone_note   (tone_note),
        .owner       (owner),
        .auto_grant  (auto_grant),
        .auto_preempt(auto_preempt)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    //   m_who    : who is sounding  (0 nobody, 1 live, 2 autoplay)
    //   m_quiet  : silent cycles still to run in a gap or hold-off (0 = none)
    //   m_in_gap : the current silence is a note-change gap (else hold-off)
    //   m_for_live : after the gap, live (1) or autoplay (0) takes over
    // ------------------------------------------------------------------
    int         m_who;
    int         m_quiet;
    bit         m_in_gap;
    bit         m_for_live;
    logic [3:0] m_note;
    bit         m_pre;

    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic model_reset();
        m_who      = 0;
        m_quiet    = 0;
        m_in_gap   = 0;
        m_for_live = 1;
        m_note     = 4'd0;
        m_pre      = 0;
    endtask

    task automatic start_gap(input bit for_live);
        m_who      = 0;
        m_in_gap   = 1;
        m_for_live = for_live;
        m_quiet    = GAP;
    endtask

    task automatic start_hold();
        m_who    = 0;
        m_in_gap = 0;
        m_quiet  = HOLD;
    endtask

    task automatic model_step();
        m_pre = 0;
        if (m_quiet > 0) begin
            if (m_in_gap) begin
                if (!m_for_live && live_on) begin
                    m_for_live = 1;
                    m_pre      = 1;
                end
                m_quiet = m_quiet - 1;
                if (m_quiet == 0) begin
                    if (m_for_live) begin
                        if (live_on) begin
                            m_who  = 1;
                            m_note = live_note;
                        end else begin
                            start_hold();
                        end
                    end else if (auto_req) begin
                        m_who  = 2;
                        m_note = auto_note;
                    end
                end
            end else begin
                m_quiet = m_quiet - 1;
                if (live_on) begin
                    m_quiet = 0;
                    m_who   = 1;
                    m_note  = live_note;
                end
            end
        end else if (m_who == 1) begin
            if (!live_on)                 start_hold();
            else if (live_note != m_note) start_gap(1);
        end else if (m_who == 2) begin
            if (live_on) begin
                start_gap(1);
                m_pre = 1;
            end else if (!auto_req) begin
                m_who = 0;
            end else if (auto_note != m_note) begin
                start_gap(0);
            end
        end else begin
            if (live_on) begin
                m_who  = 1;
                m_note = live_note;
            end else if (auto_req) begin
                m_who  = 2;
                m_note = auto_note;
            end
        end
    endtask

    function automatic logic [8:0] model_out();
        logic       on;
        logic [1:0] own;
        logic       grant;
        on    = (m_who != 0);
        own   = (m_who == 1) ? 2'b01 : (m_who == 2) ? 2'b10 : 2'b00;
        grant = (m_who == 2);
        return {on, m_note, own, grant, m_pre};
    endfunction

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic tick(input logic r, input logic lo, input logic [3:0] ln,
                        input logic ar, input logic [3:0] an);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        rst       = r;
        live_on   = lo;
        live_note = ln;
        auto_req  = ar;
        auto_note = an;
        if (r) model_reset();
        exp_q.push_back(model_out());
    endtask

    task automatic hold_for(input int n, input logic r, input logic lo,
                            input logic [3:0] ln, input logic ar,
                            input logic [3:0] an);
        for (int i = 0; i < n; i++) tick(r, lo, ln, ar, an);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tone_on",      int'(tone_on),      int'(e[8]));
            chk("tone_note",    int'(tone_note),    int'(e[7:4]));
            chk("owner",        int'(owner),        int'(e[3:2]));
            chk("auto_grant",   int'(auto_grant),   int'(e[1]));
            chk("auto_preempt", int'(auto_preempt), int'(e[0]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        live_on   = 1'b0;
        live_note = 4'd0;
        auto_req  = 1'b0;
        auto_note = 4'd0;
        model_reset();

        // Reset state, then release.
        hold_for(3, 1, 0, 4'd0, 0, 4'd0);
        hold_for(2, 0, 0, 4'd0, 0, 4'd0);

        // Live note 3 -> 7: one gap, no preempt; then release into hold-off.
        hold_for(5,  0, 1, 4'd3, 0, 4'd0);
        hold_for(10, 0, 1, 4'd7, 0, 4'd0);
        hold_for(12, 0, 0, 4'd7, 0, 4'd0);

        // Autoplay 9, live 2 preempts; live release with autoplay held,
        // hold-off, idle, then autoplay resumes.
        hold_for(10, 0, 0, 4'd0, 1, 4'd9);
        hold_for(8,  0, 1, 4'd2, 1, 4'd9);
        hold_for(14, 0, 0, 4'd2, 1, 4'd11);
        hold_for(3,  0, 0, 4'd0, 0, 4'd0);

        // Live release, re-press note 4 inside the hold-off: no gap.
        hold_for(4,  0, 1, 4'd6, 0, 4'd0);
        hold_for(3,  0, 0, 4'd6, 0, 4'd0);
        hold_for(4,  0, 1, 4'd4, 0, 4'd0);
        hold_for(10, 0, 0, 4'd4, 0, 4'd0);

        // Autoplay 1 -> 1 -> 6: gap only on the change.
        hold_for(5, 0, 0, 4'd0, 1, 4'd1);
        hold_for(5, 0, 0, 4'd0, 1, 4'd1);
        hold_for(8, 0, 0, 4'd0, 1, 4'd6);
        hold_for(3, 0, 0, 4'd0, 0, 4'd0);

        // Autoplay gap retargeted by a live press.
        hold_for(4, 0, 0, 4'd0, 1, 4'd2);
        hold_for(2, 0, 0, 4'd0, 1, 4'd5);
        hold_for(8, 0, 1, 4'd9, 1, 4'd5);
        hold_for(12, 0, 0, 4'd0, 0, 4'd0);

        // Reset in the middle of a gap, released with live 5 held.
        hold_for(3, 0, 1, 4'd3, 0, 4'd0);
        hold_for(2, 0, 1, 4'd8, 0, 4'd0);
        hold_for(2, 1, 1, 4'd5, 0, 4'd0);
        hold_for(4, 0, 1, 4'd5, 0, 4'd0);
        hold_for(10, 0, 0, 4'd5, 0, 4'd0);

        // Randomized segments.
        for (int s = 0; s < 500; s++) begin
            logic       r;
            logic       lo;
            logic       ar;
            logic [3:0] ln;
            logic [3:0] an;
            int         len;
            r   = ($urandom_range(0, 99) < 2);
            lo  = ($urandom_range(0, 99) < 40);
            ar  = ($urandom_range(0, 99) < 60);
            ln  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2))
                                              : 4'($urandom_range(0, 15));
            an  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2))
                                              : 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            hold_for(len, r, lo, ln, ar, an);
        end
        hold_for(15, 0, 0, 4'd0, 0, 4'd0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Shares the single tone generator between the live keyboard path (debounced note and valid from the key controller) and the autoplay song player. Live play always wins. Every note change inserts a short silence so repeated or changed notes are audible as separate strikes. After a live key is released, a hold-off window keeps autoplay from resuming at once. Sits between the key controller / song player and the tone/buzzer generator.

## Interface
- GAP_CYCLES, 4: silent cycles inserted on every note change or ownership change; legal range 1..255
- LIVE_HOLD, 8: silent cycles after live release before autoplay may regain the output; legal range 1..255
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- live_on  in  1  live note valid (key controller output valid)
- live_note  in  4  live note code
- auto_req  in  1  autoplay requests the output; held high for the whole note
- auto_note  in  4  autoplay note code
- tone_on  out  1  tone generator enable
- tone_note  out  4  note code to tone generator
- owner  out  2  00 none, 01 live, 10 autoplay; 11 never driven
- auto_grant  out  1  autoplay currently owns a sounding output
- auto_preempt  out  1  one-cycle pulse when autoplay loses ownership to live

## Operation
- Moore FSM with states IDLE, LIVE, AUTO, GAP and HOLD. It has a target register (LIVE or AUTO), a 4-bit note latch and an 8-bit down-counter.
- Reset (async, any time, including mid-GAP or mid-HOLD): state=IDLE, tone_on=0, tone_note=0, owner=00, auto_grant=0, auto_preempt=0, counter=0.
- IDLE: tone_on=0.
  - live_on=1: go to LIVE and latch live_note. This has priority over auto_req.
  - Else auto_req=1: go to AUTO and latch auto_note.
- LIVE: tone_on=1, tone_note=latch, owner=01.
  - live_on=0: go to HOLD and load the counter with LIVE_HOLD.
  - live_on=1 and live_note≠latch: go to GAP with target LIVE and load the counter with GAP_CYCLES.
  - auto_req is ignored.
- AUTO: tone_on=1, tone_note=latch, owner=10, auto_grant=1.
  - live_on=1: go to GAP with target LIVE, pulse auto_preempt for that one transition cycle, load GAP_CYCLES.
  - Else auto_req=0: go to IDLE.
  - Else auto_note≠latch: go to GAP with target AUTO, load GAP_CYCLES.
- GAP: tone_on=0, owner=00, tone_note holds its last value. The counter decrements every cycle.
  - live_on=1 while target=AUTO: retarget to LIVE, pulse auto_preempt, and leave the counter unreloaded.
  - On the cycle the counter reaches 1, with target LIVE:
    - live_on=1: enter LIVE and latch the current live_note.
    - Else: enter HOLD and load LIVE_HOLD.
  - On the cycle the counter reaches 1, with target AUTO:
    - auto_req=1: enter AUTO and latch the current auto_note.
    - Else: enter IDLE.
- HOLD: tone_on=0, owner=00. The counter decrements every cycle.
  - live_on=1: go straight to LIVE, latch live_note, no gap (output already silent).
  - Counter reaches 1: go to IDLE.
  - auto_req is ignored throughout HOLD.
- Note comparison is a 4-bit equality. A same-note repress is seen as live_on falling then rising, so it goes LIVE→HOLD→LIVE.

## Timing
- All outputs are registered and decoded from state and latch. No combinational input→output path.
- Input sampled at edge N appears on the outputs after edge N. Latency is 1 cycle from IDLE/HOLD to sounding.
- GAP lasts exactly GAP_CYCLES cycles with tone_on=0, counting from the first GAP cycle.
- HOLD lasts exactly LIVE_HOLD cycles unless live_on interrupts it.
- auto_preempt is high for exactly one cycle, coincident with the first GAP cycle after AUTO. It also fires on the GAP-retarget cycle.
- tone_note changes only on entry to LIVE or AUTO.
- Simultaneous live_on and auto_req in IDLE: LIVE.
- Simultaneous auto_req drop and live_on in AUTO: GAP→LIVE, with preempt.

## Test plan
- Reset mid-GAP, then live_on=1, live_note=5 → after reset release, next edge tone_on=1, tone_note=5, owner=01. During reset all outputs are 0.
- Live note 3→7, GAP_CYCLES=4 → tone_on low for exactly 4 cycles, then tone_note=7, owner=01. No auto_preempt.
- auto_req=1, auto_note=9; at cycle 10, live_on=1, note 2 → auto_preempt is a 1-cycle pulse, 4 silent cycles, then tone_note=2, owner=01, auto_grant=0.
- Live release with auto_req held, LIVE_HOLD=8 → 8 cycles tone_on=0, then 1 IDLE cycle, then AUTO with the current auto_note, auto_grant=1.
- Live release, then re-press note 4 at HOLD cycle 3 → tone_on=1, tone_note=4 the next cycle, no gap.
- auto_note 1→1→6 with auto_req held → no gap while the note is unchanged; a 4-cycle gap on the change to 6; auto_grant low during the gap.
